// File: rtl/puf_resp_reader_if.sv
`timescale 1ns/1ps
// puf_resp_reader_if
//   Word stream from the PUF response reader to the key/ID logic.
//
//   Handshake: a word moves on every rising clk edge where out_valid and
//   out_ready are both high. Once out_valid is raised, out_data and out_last
//   hold steady until that transfer happens. out_valid does not wait for
//   out_ready. The consumer may change out_ready freely.
//
//   Signals
//     out_data   master->slave  WORD_W  response word, word 0 (LSBs) first
//     out_valid  master->slave  1       out_data holds a word
//     out_last   master->slave  1       the current word is the final word
//     out_ready  slave->master  1       consumer takes the word this cycle
//
//   WORD_W must match WORD_W of the reader it is connected to.
interface puf_resp_reader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/puf_resp_reader.sv
`timescale 1ns/1ps
// puf_resp_reader
//   Reader side of the PUF response interface. On start, it latches the
//   control selector and raises puf_enable for a settle window. It then
//   captures the wide response and streams it out as WORD_W-bit words, LSB
//   word first.
//
//   Optional feature, macro PUF_MAJORITY_VOTE_EN:
//     defined   - three captures, one per settle window. The stored response
//                 is their bitwise majority.
//     undefined - one capture, stored directly.
//
//   Ports
//     clk         in   clock, rising edge
//     rst         in   synchronous reset, active-high
//     start       in   request one read. It is taken only in IDLE.
//     ctrl_in     in   [1:0] challenge/control, latched on start
//     puf_enable  out  enable to the PUF generator
//     puf_ctrl    out  [1:0] latched ctrl_in
//     puf_resp    in   [RESP_W-1:0] raw PUF response
//     bus         if   word stream (master modport of puf_resp_reader_if)
//     busy        out  FSM not IDLE
//     done        out  one-cycle pulse after the last word is accepted
//     dbg_state   out  [1:0] current FSM state (IDLE/SETTLE/SEND)
module puf_resp_reader #(
  parameter int RESP_W     = 1024,
  parameter int WORD_W     = 32,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        ctrl_in,
  output logic              puf_enable,
  output logic [1:0]        puf_ctrl,
  input  logic [RESP_W-1:0] puf_resp,
  puf_resp_reader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int NWORDS = RESP_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int NS = 3;
`else
  localparam int NS = 1;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
  localparam logic [1:0]       SMP_LAST = 2'(NS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;

  logic [1:0]                   state;
  logic [CNT_W-1:0]             settle_cnt;
  logic [1:0]                   samp_k;      // captures taken so far in this read
  logic [IDX_W-1:0]             word_idx;
  logic [NWORDS-1:0][WORD_W-1:0] resp_q;     // element 0 = response LSBs
`ifdef PUF_MAJORITY_VOTE_EN
  logic [RESP_W-1:0]            samp_a;
  logic [RESP_W-1:0]            samp_b;
`endif

  logic handshake;
  assign handshake = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      samp_k        <= '0;
      word_idx      <= '0;
      resp_q        <= '0;
      puf_enable    <= 1'b0;
      puf_ctrl      <= 2'b00;
      bus.out_valid <= 1'b0;
      done          <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      samp_a        <= '0;
      samp_b        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            puf_ctrl   <= ctrl_in;
            puf_enable <= 1'b1;
            settle_cnt <= '0;
            samp_k     <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // The counter sits at SETTLE_CYC-1 on the edge that is SETTLE_CYC
          // cycles after the window opened. That edge is the capture edge.
          if (settle_cnt == CNT_LAST) begin
            settle_cnt <= '0;
            samp_k     <= samp_k + 2'd1;
`ifdef PUF_MAJORITY_VOTE_EN
            case (samp_k)
              2'd0:    samp_a <= puf_resp;
              2'd1:    samp_b <= puf_resp;
              default: resp_q <= (samp_a & samp_b) | (samp_a & puf_resp) |
                                 (samp_b & puf_resp);
            endcase
`else
            resp_q <= puf_resp;
`endif
            if (samp_k == SMP_LAST) begin
              puf_enable    <= 1'b0;
              word_idx      <= '0;
              bus.out_valid <= 1'b1;
              state         <= SEND;
            end
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        SEND: begin
          if (handshake) begin
            if (word_idx == IDX_LAST) begin
              bus.out_valid <= 1'b0;
              done          <= 1'b1;
              state         <= IDLE;
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The word is selected from registered state only, so the output holds
  // steady under back-pressure. It reads zero whenever no word is offered.
  assign bus.out_data = bus.out_valid ? resp_q[word_idx] : '0;
  assign bus.out_last = bus.out_valid && (word_idx == IDX_LAST);
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_puf_resp_reader.sv
`timescale 1ns/1ps
// tb_puf_resp_reader
//   Directed bench for puf_resp_reader (RESP_W=1024, WORD_W=32,
//   SETTLE_CYC=16). It works in the default build and with
//   PUF_MAJORITY_VOTE_EN defined. Inputs change 1ns after the rising edge.
//   Outputs are observed on the falling edge.
module tb_puf_resp_reader;

  localparam int RESP_W     = 1024;
  localparam int WORD_W     = 32;
  localparam int SETTLE_CYC = 16;
  localparam int NWORDS     = RESP_W / WORD_W;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int NS = 3;
`else
  localparam int NS = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        ctrl_in;
  logic              puf_enable;
  logic [1:0]        puf_ctrl;
  logic [RESP_W-1:0] puf_resp;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  puf_resp_reader_if #(.WORD_W(WORD_W)) bus ();

  always #5 clk = ~clk;

  puf_resp_reader #(
    .RESP_W(RESP_W), .WORD_W(WORD_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl_in(ctrl_in),
    .puf_enable(puf_enable), .puf_ctrl(puf_ctrl), .puf_resp(puf_resp),
    .bus(bus), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [WORD_W:0] exp_q[$];  // {last, data}
  logic [WORD_W:0] mon_e;
  int  cyc = 0, done_cnt = 0, acc_cnt = 0, en_cycles = 0, valid_cycles = 0;
  int  t_start = 0, t_first = 0;
  bit  exp_done = 0, prev_stall = 0, prev_valid = 0;
  logic [WORD_W:0] stall_word;

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (rst) begin
      exp_done   = 0;
      prev_stall = 0;
      prev_valid = 0;
    end else begin
      if (exp_done) check("done_after_last", done, 1);
      exp_done = 0;
      if (puf_enable) en_cycles++;
      if (bus.out_valid) valid_cycles++;
      if (bus.out_valid && !prev_valid) t_first = cyc;
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_word", {bus.out_last, bus.out_data}, stall_word);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("word", {bus.out_last, bus.out_data}, mon_e);
          acc_cnt++;
          if (bus.out_last) exp_done = 1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      stall_word = {bus.out_last, bus.out_data};
      prev_valid = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // now=1: start is raised right away, for use from a falling edge.
  task automatic do_read(input logic [1:0] ctrl, input logic [RESP_W-1:0] a,
                         input logic [RESP_W-1:0] b, input logic [RESP_W-1:0] c,
                         input bit now);
    logic [RESP_W-1:0] e;
`ifdef PUF_MAJORITY_VOTE_EN
    e = (a & b) | (a & c) | (b & c);
`else
    e = a;
`endif
    for (int i = 0; i < NWORDS; i++)
      exp_q.push_back({(i == NWORDS - 1), e[i*WORD_W +: WORD_W]});
    if (!now) begin
      @(posedge clk);
      #1;
    end
    puf_resp     = a;
    ctrl_in      = ctrl;
    start        = 1'b1;
    en_cycles    = 0;
    valid_cycles = 0;
    @(posedge clk);  // E0
    #1;
    start   = 1'b0;
    ctrl_in = ~ctrl;
    t_start = cyc + 1;
    @(negedge clk);
    check("enable_on", puf_enable, 1);
    check("ctrl_latched", puf_ctrl, ctrl);
    check("busy_on", busy, 1);
    repeat (SETTLE_CYC) @(posedge clk);
    #1;
`ifdef PUF_MAJORITY_VOTE_EN
    puf_resp = b;
    repeat (SETTLE_CYC) @(posedge clk);
    #1;
    puf_resp = c;
    repeat (SETTLE_CYC) @(posedge clk);
    #1;
`endif
    puf_resp = ~e;  // must not reach the stream
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enable"}, puf_enable, 0);
    check({tag, "_ctrl"},   puf_ctrl, 0);
    check({tag, "_valid"},  bus.out_valid, 0);
    check({tag, "_data"},   bus.out_data, 0);
    check({tag, "_last"},   bus.out_last, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_state"},  dbg_state, 0);
  endtask

  // ---------------- test sequence ----------------
  logic [RESP_W-1:0] pat_inc, pat_b, pat_c;
  int d0, acc0, hold;
  bit tog;

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      pat_inc[i*WORD_W +: WORD_W] = WORD_W'(i);
      pat_b[i*WORD_W +: WORD_W]   = 32'hA5A5_0000 | WORD_W'(i);
      pat_c[i*WORD_W +: WORD_W]   = 32'h0F00_0000 | WORD_W'(i * 3);
    end
    rst = 1'b1; start = 1'b0; ctrl_in = 2'b00; puf_resp = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Test 2: basic read, ready always high
    d0 = done_cnt;
    do_read(2'b10, pat_inc, pat_inc, pat_inc, 0);
    wait_done(d0, 200);
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_enable_cycles", en_cycles, NS * SETTLE_CYC);
    check("t2_latency", t_first - t_start, NS * SETTLE_CYC);
    check("t2_valid_cycles", valid_cycles, NWORDS);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_busy_off", busy, 0);

    // Test 1: reset held 3 cycles mid-SEND
    d0 = done_cnt;
    do_read(2'b01, pat_b, pat_b, pat_b, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    check("t1_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    do_read(2'b11, pat_c, pat_c, pat_c, 0);
    wait_done(d0, 200);
    check("t1_rerun_done", done_cnt - d0, 1);
    check("t1_rerun_queue", exp_q.size(), 0);

    // Test 3: back-pressure, toggling ready with a 5-cycle stall at word 7
    d0 = done_cnt;
    acc0 = acc_cnt;
    hold = 0;
    tog = 1'b0;
    fork
      do_read(2'b00, ~pat_inc, ~pat_inc, ~pat_inc, 0);
      begin
        for (int k = 0; k < 600; k++) begin
          @(posedge clk);
          #1;
          if (done_cnt != d0) break;
          if (bus.out_valid && (acc_cnt - acc0 == 7) && hold < 5) begin
            bus.out_ready = 1'b0;
            hold++;
          end else begin
            tog = ~tog;
            bus.out_ready = tog;
          end
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_done(d0, 200);
    check("t3_stall_len", hold, 5);
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_words", acc_cnt - acc0, NWORDS);
    check("t3_queue_empty", exp_q.size(), 0);

    // Test 4: start pulses during SETTLE and SEND are ignored
    d0 = done_cnt;
    acc0 = acc_cnt;
    fork
      do_read(2'b01, pat_b, pat_b, pat_b, 0);
      begin
        repeat (6) @(posedge clk);
        #1 start = 1'b1; ctrl_in = 2'b11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (NS * SETTLE_CYC + 3) @(posedge clk);
        #1 start = 1'b1; ctrl_in = 2'b11;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("t4_ctrl_hold", puf_ctrl, 2'b01);
        check("t4_state_send", dbg_state, 2);
      end
    join
    wait_done(d0, 200);
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_words", acc_cnt - acc0, NWORDS);
    check("t4_latency", t_first - t_start, NS * SETTLE_CYC);
    check("t4_idle_after", busy, 0);
    check("t4_enable_off", puf_enable, 0);

`ifdef PUF_MAJORITY_VOTE_EN
    // Test 5: majority of all-1, all-0, 0x5555... is 0x5555...
    d0 = done_cnt;
    do_read(2'b10, {RESP_W{1'b1}}, {RESP_W{1'b0}}, {(RESP_W/2){2'b01}}, 0);
    wait_done(d0, 300);
    check("t5_done_count", done_cnt - d0, 1);
    check("t5_latency", t_first - t_start, 48);
    check("t5_queue_empty", exp_q.size(), 0);
`endif

    // Test 6: start in the done cycle is accepted
    d0 = done_cnt;
    do_read(2'b10, pat_c, pat_c, pat_c, 0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("t6_done_seen", done, 1);
    check("t6_idle_in_done", busy, 0);
    do_read(2'b01, pat_inc, pat_inc, pat_inc, 1);
    wait_done(d0 + 1, 300);
    check("t6_done_count", done_cnt - d0, 2);
    check("t6_latency", t_first - t_start, NS * SETTLE_CYC);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
